// File: rtl/mux_share_arbiter_if.sv
// Bus bundle between two requesters and the shared 2:1 selector arbiter.
// Carries the request levels, both source words, the grants, the mux
// select and the registered mux output with its valid flag.
//   master : requester side (drives req_*/data_*, observes grants and output)
//   slave  : arbiter side (observes req_*/data_*, drives grants and output)
interface mux_share_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req_x;
    logic             req_y;
    logic [WIDTH-1:0] data_x;
    logic [WIDTH-1:0] data_y;
    logic             gnt_x;
    logic             gnt_y;
    logic             sel;
    logic [WIDTH-1:0] m_out;
    logic             m_valid;

    modport master (
        output req_x, req_y, data_x, data_y,
        input  gnt_x, gnt_y, sel, m_out, m_valid
    );

    modport slave (
        input  req_x, req_y, data_x, data_y,
        output gnt_x, gnt_y, sel, m_out, m_valid
    );
endinterface

// File: rtl/mux_share_arbiter.sv
// Arbiter for a shared WIDTH-bit 2:1 selector (M = sel ? Y : X).
// Grants X or Y using round-robin with a bounded hold of HOLD_MAX cycles,
// drives the selector's sel and registers the selected word with a valid flag.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mux_share_arbiter_if.slave (req_x/req_y/data_x/data_y in,
//          gnt_x/gnt_y/sel/m_out/m_valid out, all outputs registered)
// Build option:
//   MUX_ARB_FIXED_PRIO_EN : X wins every tie and is never preempted;
//                           Y is still preempted by X after HOLD_MAX cycles.
module mux_share_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_share_arbiter_if.slave   bus
);
    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_X = 2'd1,
        OWN_Y = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             hold_done;
    logic             sel_next;
    logic             gnt_x_q;
    logic             gnt_y_q;
    logic             sel_q;
    logic [WIDTH-1:0] m_out_q;
    logic             m_valid_q;

    assign hold_done = (cnt == HOLD_LAST);

`ifndef MUX_ARB_FIXED_PRIO_EN
    // Round-robin pointer: 1 when Y was granted most recently
    logic last_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_y <= 1'b1;
        end else if (state_next == OWN_Y) begin
            last_y <= 1'b1;
        end else if (state_next == OWN_X) begin
            last_y <= 1'b0;
        end
    end
`endif

    // Next-state, hold counter and select decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sel_next   = sel_q;

        case (state)
            IDLE: begin
                if (bus.req_x && bus.req_y) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                    state_next = OWN_X;
`else
                    state_next = last_y ? OWN_X : OWN_Y;
`endif
                end else if (bus.req_x) begin
                    state_next = OWN_X;
                end else if (bus.req_y) begin
                    state_next = OWN_Y;
                end
            end
            OWN_X: begin
                if (!bus.req_x) begin
                    state_next = bus.req_y ? OWN_Y : IDLE;
                end
`ifndef MUX_ARB_FIXED_PRIO_EN
                else if (bus.req_y && hold_done) begin
                    state_next = OWN_Y;
                end
`endif
            end
            OWN_Y: begin
                if (!bus.req_y) begin
                    state_next = bus.req_x ? OWN_X : IDLE;
                end else if (bus.req_x && hold_done) begin
                    state_next = OWN_X;
                end
            end
            default: state_next = IDLE;
        endcase

        // Clear on any state change, otherwise count up and saturate
        if (state_next != state) begin
            cnt_next = '0;
        end else if ((state != IDLE) && !hold_done) begin
            cnt_next = cnt + CW'(1);
        end

        // sel keeps its value through IDLE so the mux never glitches
        if (state_next == OWN_X) begin
            sel_next = 1'b0;
        end else if (state_next == OWN_Y) begin
            sel_next = 1'b1;
        end
    end

    // State and output registers; m_out uses the already-registered sel
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt_x_q   <= 1'b0;
            gnt_y_q   <= 1'b0;
            sel_q     <= 1'b0;
            m_out_q   <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            gnt_x_q   <= (state_next == OWN_X);
            gnt_y_q   <= (state_next == OWN_Y);
            sel_q     <= sel_next;
            m_out_q   <= sel_q ? bus.data_y : bus.data_x;
            m_valid_q <= (state != IDLE);
        end
    end

    assign bus.gnt_x   = gnt_x_q;
    assign bus.gnt_y   = gnt_y_q;
    assign bus.sel     = sel_q;
    assign bus.m_out   = m_out_q;
    assign bus.m_valid = m_valid_q;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed, table-driven bench for mux_share_arbiter (WIDTH=4, HOLD_MAX=4).
// Each table row gives the inputs applied before a clock edge and the
// outputs expected just after it. A hand-written sequence covers the
// saturated-hold corner.
module tb_mux_share_arbiter;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned HOLD_MAX = 4;

    logic clk;
    logic rst;

    mux_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_share_arbiter #(
        .WIDTH    (WIDTH),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             req_x;
        logic             req_y;
        logic [WIDTH-1:0] data_x;
        logic [WIDTH-1:0] data_y;
        logic             gnt_x;
        logic             gnt_y;
        logic             sel;
        logic [WIDTH-1:0] m_out;
        logic             m_valid;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    function automatic void add(input logic r, input logic rx, input logic ry,
                                input logic [WIDTH-1:0] dx, input logic [WIDTH-1:0] dy,
                                input logic gx, input logic gy, input logic s,
                                input logic [WIDTH-1:0] mo, input logic mv);
        vec_t v;
        v.rst = r;  v.req_x = rx; v.req_y = ry; v.data_x = dx; v.data_y = dy;
        v.gnt_x = gx; v.gnt_y = gy; v.sel = s; v.m_out = mo; v.m_valid = mv;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.req_x = 1'b0; bus.req_y = 1'b0;
        bus.data_x = '0;  bus.data_y = '0;

`ifndef MUX_ARB_FIXED_PRIO_EN
        // Reset held with req_x high, then first grant and first word
        add(1, 1, 0, 4'hA, 4'h5, 0, 0, 0, 4'h0, 0);
        add(1, 1, 0, 4'hA, 4'h5, 0, 0, 0, 4'h0, 0);
        add(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 4'hA, 0);
        add(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 4'hA, 1);
        // Reset mid-grant aborts, then X re-arbitrated from IDLE
        add(1, 1, 0, 4'hA, 4'h5, 0, 0, 0, 4'h0, 0);
        add(0, 1, 0, 4'hA, 4'h5, 1, 0, 0, 4'hA, 0);
        // Tie from reset: 4 X, 4 Y, 4 X, 4 Y; m_out trails sel by one
        add(1, 0, 0, 4'h3, 4'hC, 0, 0, 0, 4'h0, 0);
        for (int k = 0; k < 16; k++) begin
            logic own_y;
            logic prev_y;
            own_y  = ((k / 4) % 2) == 1;
            prev_y = (k == 0) ? 1'b0 : (((k - 1) / 4) % 2) == 1;
            add(0, 1, 1, 4'h3, 4'hC, !own_y, own_y, own_y,
                prev_y ? 4'hC : 4'h3, k != 0);
        end
        // Y preempted back to X, then release handover X -> Y
        add(0, 1, 1, 4'h3, 4'hC, 1, 0, 0, 4'hC, 1);
        add(0, 0, 1, 4'h3, 4'hC, 0, 1, 1, 4'h3, 1);
        add(0, 0, 1, 4'h3, 4'hC, 0, 1, 1, 4'hC, 1);
        // Both drop: IDLE keeps sel=1, m_valid falls one edge later
        add(0, 0, 0, 4'h3, 4'hC, 0, 0, 1, 4'hC, 1);
        add(0, 0, 0, 4'h3, 4'hC, 0, 0, 1, 4'hC, 0);
        add(0, 0, 0, 4'h3, 4'hC, 0, 0, 1, 4'hC, 0);
        // Lone requester Y for 20 cycles, never preempted
        add(0, 0, 1, 4'h3, 4'h6, 0, 1, 1, 4'h6, 0);
        for (int k = 0; k < 19; k++) add(0, 0, 1, 4'h3, 4'h6, 0, 1, 1, 4'h6, 1);
        // Y -> X on release, idle, then tie goes to Y since X was last
        add(0, 1, 0, 4'h3, 4'h6, 1, 0, 0, 4'h6, 1);
        add(0, 0, 0, 4'h3, 4'h6, 0, 0, 0, 4'h3, 1);
        add(0, 1, 1, 4'h3, 4'h6, 0, 1, 1, 4'h3, 0);
        add(0, 1, 1, 4'h3, 4'h6, 0, 1, 1, 4'h6, 1);
`else
        // X wins the tie and is never preempted
        add(1, 0, 0, 4'h3, 4'hC, 0, 0, 0, 4'h0, 0);
        add(0, 1, 1, 4'h3, 4'hC, 1, 0, 0, 4'h3, 0);
        for (int k = 0; k < 11; k++) add(0, 1, 1, 4'h3, 4'hC, 1, 0, 0, 4'h3, 1);
        // Y takes over on release, X preempts after exactly HOLD_MAX cycles
        add(0, 0, 1, 4'h3, 4'hC, 0, 1, 1, 4'h3, 1);
        for (int k = 0; k < 3; k++) add(0, 1, 1, 4'h3, 4'hC, 0, 1, 1, 4'hC, 1);
        add(0, 1, 1, 4'h3, 4'hC, 1, 0, 0, 4'hC, 1);
        add(0, 1, 1, 4'h3, 4'hC, 1, 0, 0, 4'h3, 1);
        add(0, 1, 1, 4'h3, 4'hC, 1, 0, 0, 4'h3, 1);
`endif

        foreach (vecs[i]) begin
            rst        = vecs[i].rst;
            bus.req_x  = vecs[i].req_x;
            bus.req_y  = vecs[i].req_y;
            bus.data_x = vecs[i].data_x;
            bus.data_y = vecs[i].data_y;
            step();
            chk($sformatf("row%0d gnt_x", i),   32'(bus.gnt_x),   32'(vecs[i].gnt_x));
            chk($sformatf("row%0d gnt_y", i),   32'(bus.gnt_y),   32'(vecs[i].gnt_y));
            chk($sformatf("row%0d sel", i),     32'(bus.sel),     32'(vecs[i].sel));
            chk($sformatf("row%0d m_out", i),   32'(bus.m_out),   32'(vecs[i].m_out));
            chk($sformatf("row%0d m_valid", i), 32'(bus.m_valid), 32'(vecs[i].m_valid));
            chk($sformatf("row%0d excl", i),    32'(bus.gnt_x & bus.gnt_y), 32'(0));
        end

        // Lone X saturates its hold counter; a new Y request then
        // preempts on the very next edge (never, with fixed priority)
        rst = 1'b1; bus.req_x = 1'b0; bus.req_y = 1'b0;
        step();
        rst = 1'b0; bus.req_x = 1'b1;
        repeat (10) step();
        chk("sat x owns", 32'(bus.gnt_x), 32'(1));
        bus.req_y = 1'b1;
        n = 0;
        while (!bus.gnt_y && n < 20) begin
            step();
            n++;
        end
`ifndef MUX_ARB_FIXED_PRIO_EN
        chk("sat preempt cycles", 32'(n), 32'(1));
        chk("sat gnt_x dropped", 32'(bus.gnt_x), 32'(0));
`else
        chk("sat no preempt cycles", 32'(n), 32'(20));
        chk("sat gnt_x kept", 32'(bus.gnt_x), 32'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
